// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: parameter defaults, event record
// width and the key-index <-> bus-bit mapping also used by the CPU key logic.
package keypad_scanner_pkg;

    localparam int DEF_COLS      = 4;
    localparam int DEF_ROWS      = 4;
    localparam int DEF_SCAN_DIV  = 1;
    localparam int DEF_DEBOUNCE  = 1;
    localparam int DEF_EVT_DEPTH = 4;

    // Key index k for column c and row r of a keypad with the given row count.
    function automatic int key_index(input int c, input int r, input int rows);
        return c * rows + r;
    endfunction

    // Bus bit that carries key k on a bitmap of the given key count (MSB = key 0).
    function automatic int key_bit(input int k, input int keys);
        return keys - 1 - k;
    endfunction

    // Width of the key-code field in an event record.
    function automatic int evt_code_width(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_scanner_evt_fifo.sv
// First-word-fall-through event queue between the scanner emitter and the CPU.
// The head entry is presented as soon as it is written and is held until
// the consumer accepts it; a push and pop may coincide even when full.
module keypad_evt_fifo
    import keypad_scanner_pkg::*;
#(
    parameter int DEPTH = DEF_EVT_DEPTH,
    parameter int WIDTH = 5
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNTW'(DEPTH));
    assign out_valid = (count != '0);
    assign do_pop    = out_valid && out_ready;
    assign do_push   = push && (!full || do_pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards anything queued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: strobes one column at a time, samples the active-low
// rows, debounces whole frames, publishes a stable bitmap and queues
// press/release events for the CPU.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int DEBOUNCE  = DEF_DEBOUNCE,
    parameter int EVT_DEPTH = DEF_EVT_DEPTH
)
(
    input  logic                           clk,
    input  logic                           reset_n,
    output logic [COLS-1:0]                column,
    input  logic [ROWS-1:0]                row,
    output logic [ROWS*COLS-1:0]           value,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [$clog2(ROWS*COLS)-1:0]   evt_code,
    output logic                           evt_pressed
);

    localparam int N  = ROWS * COLS;
    localparam int KW = evt_code_width(ROWS, COLS);
    localparam int CW = $clog2(COLS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE + 1);

    // Internal bitmaps are indexed by key number (bit k = key k).
    logic [DW-1:0]  dwell;
    logic [CW-1:0]  col_idx;
    logic [N-1:0]   raw_frame;
    logic [N-1:0]   frame_now;
    logic [N-1:0]   prev_frame;
    logic [N-1:0]   value_k;
    logic [N-1:0]   pending;
    logic [SW-1:0]  streak;
    logic [SW-1:0]  streak_next;
    logic           last_dwell;
    logic           frame_end;
    logic           commit;
    logic           push;
    logic           fifo_full;
    logic [KW-1:0]  pick_idx;
    logic [KW:0]    fifo_out;

    assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
    assign frame_end  = last_dwell && (col_idx == CW'(COLS - 1));

    // Drive the one-hot strobe; column index c appears on bit COLS-1-c.
    always_comb begin
        column = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_idx == CW'(c)) begin
                column[COLS-1-c] = 1'b1;
            end
        end
    end

    // Frame as it stands including the column being sampled on this edge.
    always_comb begin
        frame_now = raw_frame;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (col_idx == CW'(c)) begin
                    frame_now[key_index(c, r, ROWS)] = ~row[ROWS-1-r];
                end
            end
        end
    end

    // Column dwell timer and column advance; rows are captured at dwell end.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dwell     <= '0;
            col_idx   <= '0;
            raw_frame <= '0;
        end else if (last_dwell) begin
            dwell     <= '0;
            raw_frame <= frame_now;
            col_idx   <= (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Stability streak for the frame completing now, saturating at DEBOUNCE.
    always_comb begin
        if (frame_now == prev_frame) begin
            streak_next = (streak == SW'(DEBOUNCE)) ? streak : streak + SW'(1);
        end else begin
            streak_next = SW'(1);
        end
    end

    // A stable, changed frame commits only once earlier events are all queued.
    assign commit = frame_end && (streak_next >= SW'(DEBOUNCE)) &&
                    (frame_now != value_k) && (pending == '0);

    // Frame-end debounce state and committed key bitmap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_frame <= '0;
            streak     <= '0;
            value_k    <= '0;
        end else if (frame_end) begin
            prev_frame <= frame_now;
            streak     <= streak_next;
            if (commit) begin
                value_k <= frame_now;
            end
        end
    end

    // Lowest changed key still waiting to be turned into an event.
    always_comb begin
        pick_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending[k]) begin
                pick_idx = KW'(k);
            end
        end
    end

    assign push = (pending != '0) && !fifo_full;

    // Changed-key set: loaded on commit, drained one key per accepted push.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= '0;
        end else if (commit) begin
            pending <= value_k ^ frame_now;
        end else if (push) begin
            pending[pick_idx] <= 1'b0;
        end
    end

    keypad_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .WIDTH (KW + 1)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({pick_idx, value_k[pick_idx]}),
        .full      (fifo_full),
        .out_valid (evt_valid),
        .out_ready (evt_ready),
        .out_data  (fifo_out)
    );

    assign evt_code    = fifo_out[KW:1];
    assign evt_pressed = fifo_out[0];

    // Publish the bitmap with key k on bus bit N-1-k.
    always_comb begin
        value = '0;
        for (int k = 0; k < N; k++) begin
            value[key_bit(k, N)] = value_k[k];
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 4x4 keypad, SCAN_DIV=2, DEBOUNCE=3,
// EVT_DEPTH=4, with a behavioural key matrix driving the row returns.
module tb_keypad_scanner;

    logic        clk;
    logic        reset_n;
    logic [3:0]  column;
    logic [3:0]  row;
    logic [15:0] value;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_code;
    logic        evt_pressed;

    logic [15:0] keys_down;
    logic        rows_all_low;
    int          cyc;
    int          total;
    int          bad;

    keypad_scanner #(
        .COLS      (4),
        .ROWS      (4),
        .SCAN_DIV  (2),
        .DEBOUNCE  (3),
        .EVT_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .column      (column),
        .row         (row),
        .value       (value),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_pressed (evt_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a held key k = c*4+r pulls row bit 3-r low while column bit 3-c is high.
    always_comb begin
        row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (column[3-c] && keys_down[c*4+r]) begin
                    row[3-r] = 1'b0;
                end
            end
        end
        if (rows_all_low) begin
            row = 4'b0000;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic waitUntil(input int n);
        while (cyc < n) tick();
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input logic ready);
        keys_down = keys;
        evt_ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [15:0] keyMask(input int k);
        logic [15:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [3:0]  exp_col;
        logic        seen_val;
        logic        seen_evt;
        logic [4:0]  evq[$];
        logic [31:0] got;
        int          exp_code[10];
        int          exp_pr[10];

        total = 0;
        bad = 0;
        cyc = 0;
        reset_n = 1'b0;
        rows_all_low = 1'b1;
        applyStimulus(16'h0000, 1'b0);

        // Reset held with every row pulled low.
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("reset_column", column, 4'b1000);
            checkOutput("reset_value", value, 16'h0000);
            checkOutput("reset_evt_valid", evt_valid, 1'b0);
            tick();
        end

        // Strobe order after release, two cycles per column, then wrap.
        rows_all_low = 1'b0;
        reset_n = 1'b1;
        cyc = 0;
        for (int e = 0; e < 10; e++) begin
            exp_col = 4'b1000 >> ((e / 2) % 4);
            checkOutput("strobe_order", column, exp_col);
            tick();
        end

        // Single key 5 (c=1, r=1): press, commit at cycle 24, event, release.
        $display("[TB] single key");
        doReset();
        applyStimulus(keyMask(5), 1'b0);
        waitUntil(23);
        checkOutput("single_value_early", value, 16'h0000);
        tick();
        checkOutput("single_value_commit", value, 16'h0400);
        checkOutput("single_no_evt_yet", evt_valid, 1'b0);
        tick();
        checkOutput("single_evt_valid", evt_valid, 1'b1);
        checkOutput("single_evt_code", evt_code, 4'd5);
        checkOutput("single_evt_pressed", evt_pressed, 1'b1);
        tick();
        checkOutput("single_hold_valid", evt_valid, 1'b1);
        checkOutput("single_hold_code", evt_code, 4'd5);
        applyStimulus(keyMask(5), 1'b1);
        tick();
        checkOutput("single_popped", evt_valid, 1'b0);
        waitUntil(32);
        applyStimulus(16'h0000, 1'b1);
        waitUntil(55);
        checkOutput("release_value_early", value, 16'h0400);
        tick();
        checkOutput("release_value_commit", value, 16'h0000);
        tick();
        checkOutput("release_evt_valid", evt_valid, 1'b1);
        checkOutput("release_evt_code", evt_code, 4'd5);
        checkOutput("release_evt_pressed", evt_pressed, 1'b0);
        tick();
        checkOutput("release_popped", evt_valid, 1'b0);

        // Bounce: two frames down, one up, three times; nothing may commit.
        $display("[TB] bounce rejection");
        doReset();
        seen_val = 1'b0;
        seen_evt = 1'b0;
        while (cyc < 100) begin
            if (cyc < 72 && ((cyc / 8) % 3) != 2) begin
                applyStimulus(keyMask(5), 1'b1);
            end else begin
                applyStimulus(16'h0000, 1'b1);
            end
            seen_val = seen_val | (value != 16'h0000);
            seen_evt = seen_evt | evt_valid;
            tick();
        end
        checkOutput("bounce_value", seen_val, 1'b0);
        checkOutput("bounce_events", seen_evt, 1'b0);

        // Five keys at once with the consumer stalled, then drained.
        $display("[TB] multi-key backpressure");
        doReset();
        applyStimulus(keyMask(0) | keyMask(3) | keyMask(9) | keyMask(15) | keyMask(6), 1'b0);
        waitUntil(30);
        checkOutput("multi_value", value, 16'h9241);
        checkOutput("multi_stall_valid", evt_valid, 1'b1);
        checkOutput("multi_stall_code", evt_code, 4'd0);
        checkOutput("multi_stall_pressed", evt_pressed, 1'b1);
        waitUntil(32);
        applyStimulus(16'h0000, 1'b0);
        waitUntil(65);
        checkOutput("multi_release_deferred", value, 16'h9241);
        checkOutput("multi_stall_head", evt_code, 4'd0);
        tick();
        applyStimulus(16'h0000, 1'b1);
        while (cyc < 100) begin
            if (evt_valid) begin
                evq.push_back({evt_code, evt_pressed});
            end
            tick();
        end
        exp_code = '{0, 3, 6, 9, 15, 0, 3, 6, 9, 15};
        exp_pr   = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        checkOutput("multi_evt_count", evq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            got = (i < evq.size()) ? {27'd0, evq[i]} : 32'hFFFF_FFFF;
            checkOutput($sformatf("multi_evt_%0d", i), got, (exp_code[i] << 1) | exp_pr[i]);
        end
        checkOutput("multi_final_value", value, 16'h0000);

        // Reset while three events sit in the queue.
        $display("[TB] reset mid-emission");
        doReset();
        applyStimulus(keyMask(1) | keyMask(2) | keyMask(4), 1'b0);
        waitUntil(27);
        checkOutput("midrst_pre_valid", evt_valid, 1'b1);
        checkOutput("midrst_pre_code", evt_code, 4'd1);
        reset_n = 1'b0;
        applyStimulus(16'h0000, 1'b1);
        tick();
        checkOutput("midrst_valid", evt_valid, 1'b0);
        checkOutput("midrst_value", value, 16'h0000);
        checkOutput("midrst_column", column, 4'b1000);
        tick();
        reset_n = 1'b1;
        cyc = 0;
        seen_evt = 1'b0;
        while (cyc < 40) begin
            seen_evt = seen_evt | evt_valid;
            tick();
        end
        checkOutput("midrst_no_stale", seen_evt, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
